vga_pixel_feeder: RTL and testbench

//  Upstream stage of the 800x600 VGA timing generator. Reads the framebuffer

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_pixel_fifo.sv | 89 ++++++++
 rtl/vga_pixel_feeder.sv | 149 ++++++++++++++
 tb/tb_vga_pixel_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel feeder.
//   H_ACTIVE / V_ACTIVE : visible raster size
//   PIX_W / ADDR_W      : pixel and framebuffer word-address widths
//   RGB slice positions : {R[3:0], G[3:0], B[3:0]} packing of a pixel
//   feed_state_e        : feeder fetch state
package vga_pkg;

  localparam int H_ACTIVE    = 800;
  localparam int V_ACTIVE    = 600;
  localparam int PIX_W       = 12;
  localparam int ADDR_W      = 19;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;

  localparam int RED_MSB = 11;
  localparam int RED_LSB = 8;
  localparam int GRN_MSB = 7;
  localparam int GRN_LSB = 4;
  localparam int BLU_MSB = 3;
  localparam int BLU_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } feed_state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous show-ahead pixel FIFO. The head entry is always visible on
// data_out (zero when empty); pop advances it on the next clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push/data_in : write one entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; overrides push and pop
//   data_out     : head entry, all zero when empty
//   level        : occupancy, one bit wider than the pointers
//   empty, full  : occupancy flags
module vga_pixel_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_s;
  logic          rd_s;

  assign empty    = (level_q == {(AW+1){1'b0}});
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign level    = level_q;
  assign data_out = empty ? {DW{1'b0}} : mem_q[rd_ptr_q];
  assign wr_s     = push && !full;
  assign rd_s     = pop && !empty;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {(AW+1){1'b0}};
    end else begin
      if (wr_s) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_s, rd_s})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Framebuffer-to-timing-stage pixel feeder. Reads the framebuffer linearly
// through a fixed-latency read port and hands pixels to the timing stage
// out of a show-ahead FIFO; frame_start restarts the walk at address 0.
//   MAX10_CLK1_50 : pixel/system clock (posedge)
//   reset_n       : asynchronous active-low reset
//   frame_start   : one-cycle restart pulse, highest priority
//   pix_req       : timing stage consumes pix_data this cycle
//   pix_data      : FIFO head pixel, 12'h000 when empty
//   pix_valid     : FIFO not empty
//   underflow     : sticky, pix_req while empty; cleared by frame_start
//   fifo_level    : FIFO occupancy
//   mem_rd_en     : framebuffer read strobe
//   mem_addr      : read address, valid with mem_rd_en
//   mem_rd_data   : read data, RD_LAT cycles after mem_rd_en
module vga_pixel_feeder #(
  parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int   FIFO_DEPTH = 16,
  parameter int   RD_LAT     = 2,
  localparam int  LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       MAX10_CLK1_50,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic                       pix_req,
  output logic [vga_pkg::PIX_W-1:0]  pix_data,
  output logic                       pix_valid,
  output logic                       underflow,
  output logic [LVL_W-1:0]           fifo_level,
  output logic                       mem_rd_en,
  output logic [vga_pkg::ADDR_W-1:0] mem_addr,
  input  logic [vga_pkg::PIX_W-1:0]  mem_rd_data
);

  import vga_pkg::*;

  localparam int                FRAME_LEN = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  feed_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic              underflow_q, underflow_d;

  logic [LVL_W-1:0]  inflight_s;
  logic [LVL_W-1:0]  fifo_level_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              credit_ok_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;

  // Reads currently travelling through the memory pipeline.
  always_comb begin
    inflight_s = {LVL_W{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + LVL_W'(vld_pipe_q[i]);
    end
  end

  // Every read already issued owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok_s = ({1'b0, fifo_level_s} + {1'b0, inflight_s}) < (LVL_W+1)'(FIFO_DEPTH);

  // A restart discards both the returning word and the consumer's request.
  assign push_s = vld_pipe_q[RD_LAT-1] && !frame_start && !fifo_full_s;
  assign pop_s  = pix_req && !fifo_empty_s && !frame_start;

  // Fetch FSM, address counter, read-valid pipe and sticky underflow.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    vld_pipe_d  = vld_pipe_q;
    underflow_d = underflow_q;
    issue_s     = 1'b0;
    if (frame_start) begin
      state_d     = ST_FETCH;
      addr_d      = {ADDR_W{1'b0}};
      vld_pipe_d  = {RD_LAT{1'b0}};
      underflow_d = 1'b0;
    end else begin
      issue_s       = (state_q == ST_FETCH) && credit_ok_s;
      vld_pipe_d[0] = issue_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
      end
      if (pix_req && fifo_empty_s) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
      if (issue_s) begin
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        addr_d = addr_q;
      end
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_FETCH: begin
          if (issue_s && (addr_q == LAST_ADDR)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Feeder state registers.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      vld_pipe_q  <= {RD_LAT{1'b0}};
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      vld_pipe_q  <= vld_pipe_d;
      underflow_q <= underflow_d;
    end
  end

  vga_pixel_fifo #(
    .DW    (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (MAX10_CLK1_50),
    .rst_n    (reset_n),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (frame_start),
    .data_in  (mem_rd_data),
    .data_out (pix_data),
    .level    (fifo_level_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s)
  );

  assign pix_valid  = !fifo_empty_s;
  assign underflow  = underflow_q;
  assign fifo_level = fifo_level_s;
  assign mem_rd_en  = issue_s;
  assign mem_addr   = addr_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder. u_dut0 is the default 800x600,
// RD_LAT=2 build; u_dut1 is a 10x4 frame with RD_LAT=4 so a complete frame
// fits in a short run. Each has a memory model returning addr[11:0].
module tb_vga_pixel_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        fs0, req0, pv0, uf0, rd0;
  logic [11:0] pd0, md0;
  logic [4:0]  lvl0;
  logic [18:0] ad0;
  logic        fs1, req1, pv1, uf1, rd1;
  logic [11:0] pd1, md1;
  logic [4:0]  lvl1;
  logic [18:0] ad1;

  vga_pixel_feeder u_dut0 (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .frame_start(fs0), .pix_req(req0),
    .pix_data(pd0), .pix_valid(pv0), .underflow(uf0), .fifo_level(lvl0),
    .mem_rd_en(rd0), .mem_addr(ad0), .mem_rd_data(md0)
  );

  vga_pixel_feeder #(.H_ACTIVE(10), .V_ACTIVE(4), .RD_LAT(4)) u_dut1 (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .frame_start(fs1), .pix_req(req1),
    .pix_data(pd1), .pix_valid(pv1), .underflow(uf1), .fifo_level(lvl1),
    .mem_rd_en(rd1), .mem_addr(ad1), .mem_rd_data(md1)
  );

  // Fixed-latency memory models: data = address[11:0].
  logic [11:0] mp0 [2];
  logic [11:0] mp1 [4];
  always @(posedge clk) begin
    mp0[0] <= ad0[11:0];
    mp0[1] <= mp0[0];
    mp1[0] <= ad1[11:0];
    for (int i = 1; i < 4; i++) mp1[i] <= mp1[i-1];
  end
  assign md0 = mp0[1];
  assign md1 = mp1[3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Read logs, expected pixel counters and max level seen.
  logic [18:0] rdq0[$];
  logic [18:0] rdq1[$];
  int exp0 = 0;
  int exp1 = 0;
  int max_lvl1 = 0;

  // Record reads and check every accepted pixel against the running sequence.
  always @(negedge clk) begin
    if (rd0) rdq0.push_back(ad0);
    if (rd1) rdq1.push_back(ad1);
    if (fs0) exp0 <= 0;
    else if (req0 && pv0) begin
      check_val("pix0_seq", {20'd0, pd0}, {20'd0, exp0[11:0]});
      exp0 <= exp0 + 1;
    end
    if (fs1) exp1 <= 0;
    else if (req1 && pv1) begin
      check_val("pix1_seq", {20'd0, pd1}, {20'd0, exp1[11:0]});
      exp1 <= exp1 + 1;
    end
    if (int'(lvl1) > max_lvl1) max_lvl1 <= int'(lvl1);
  end

  task automatic pulse_fs0();
    @(posedge clk); #1 fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pix_data"},  {20'd0, pd0}, 32'd0);
    check_val({tag, "_pix_valid"}, {31'd0, pv0}, 32'd0);
    check_val({tag, "_underflow"}, {31'd0, uf0}, 32'd0);
    check_val({tag, "_level"},     {27'd0, lvl0}, 32'd0);
    check_val({tag, "_rd_en"},     {31'd0, rd0}, 32'd0);
    check_val({tag, "_addr"},      {13'd0, ad0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit found;
    reset_n = 1'b0; fs0 = 1'b0; req0 = 1'b0; fs1 = 1'b0; req1 = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    rdq0.delete();
    repeat (5) @(negedge clk);
    check_val("idle_no_reads", rdq0.size(), 32'd0);

    // Fill after frame_start with no consumer
    pulse_fs0();
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      if (pv0) begin found = 1'b1; lat = k; end
    end
    check_val("fill_latency", lat, 32'd4);
    repeat (30) @(negedge clk);
    check_val("fill_reads", rdq0.size(), 32'd16);
    for (int i = 0; i < rdq0.size(); i++) check_val("fill_addr", {13'd0, rdq0[i]}, i);
    check_val("fill_level", {27'd0, lvl0}, 32'd16);
    check_val("fill_head",  {20'd0, pd0}, 32'd0);
    check_val("fill_valid", {31'd0, pv0}, 32'd1);
    check_val("fill_rd_off", {31'd0, rd0}, 32'd0);

    // Streaming with pix_req held
    @(posedge clk); #1 req0 = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check_val("stream_no_underflow", {31'd0, uf0}, 32'd0);

    // Restart mid-stream with reads in flight and a same-cycle request
    @(posedge clk); #1 fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0; req0 = 1'b0; rdq0.delete();
    @(negedge clk);
    check_val("flush_level", {27'd0, lvl0}, 32'd0);
    check_val("flush_valid", {31'd0, pv0}, 32'd0);
    check_val("flush_rd_en", {31'd0, rd0}, 32'd1);
    check_val("flush_addr",  {13'd0, ad0}, 32'd0);
    repeat (30) @(negedge clk);
    check_val("refill_reads", rdq0.size(), 32'd16);
    check_val("refill_level", {27'd0, lvl0}, 32'd16);
    check_val("late_data_dropped", {20'd0, pd0}, 32'd0);
    @(posedge clk); #1 req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    check_val("after_3_pops", {20'd0, pd0}, 32'd3);

    // Underflow: request in the cycle right after frame_start
    @(posedge clk); #1 fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check_val("uf_pix_data", {20'd0, pd0}, 32'd0);
    check_val("uf_pix_valid", {31'd0, pv0}, 32'd0);
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    check_val("uf_set", {31'd0, uf0}, 32'd1);
    repeat (10) @(negedge clk);
    check_val("uf_sticky", {31'd0, uf0}, 32'd1);
    pulse_fs0();
    @(negedge clk);
    check_val("uf_cleared", {31'd0, uf0}, 32'd0);

    // Small frame, RD_LAT=4, pix_req toggling every cycle
    rdq1.delete();
    @(posedge clk); #1 fs1 = 1'b1;
    @(posedge clk); #1 fs1 = 1'b0;
    repeat (25) @(posedge clk);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1 req1 = (c % 2 == 0);
    end
    req1 = 1'b0;
    @(negedge clk);
    check_val("small_pops", exp1, 32'd40);
    check_val("small_reads", rdq1.size(), 32'd40);
    check_val("small_last_addr", (rdq1.size() > 0) ? {13'd0, rdq1[rdq1.size()-1]} : 32'hFFFF_FFFF, 32'd39);
    check_val("small_max_level", max_lvl1, 32'd16);
    check_val("small_done_rd_off", {31'd0, rd1}, 32'd0);
    check_val("small_done_empty", {31'd0, pv1}, 32'd0);

    // Reset mid-frame once address 1234 is issued
    pulse_fs0();
    req0 = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (rd0 && ad0 == 19'd1234) found = 1'b1;
    end
    check_val("addr1234_reached", {31'd0, found}, 32'd1);
    #1 reset_n = 1'b0; req0 = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; rdq0.delete();
    repeat (10) @(negedge clk);
    check_val("midrst_idle_reads", rdq0.size(), 32'd0);
    check_val("midrst_idle_valid", {31'd0, pv0}, 32'd0);
    pulse_fs0();
    repeat (30) @(negedge clk);
    check_val("midrst_restart_reads", rdq0.size(), 32'd16);
    check_val("midrst_restart_addr", (rdq0.size() > 0) ? {13'd0, rdq0[0]} : 32'hFFFF_FFFF, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
